// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: PC/instruction widths, reset PC, fetch buffer entry
// and the opcode fields that decode matches on.
package cpu_pkg;

  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;
  localparam int CODE_AW = 9;
  localparam int DEPTH   = 2;

  localparam logic [PC_W-1:0] RESET_PC = '0;

  // Opcode fields owned by decode; kept here so both stages agree on encodings.
  localparam int         OP_BRANCH_LSB = 25;
  localparam logic [2:0] OP_BRANCH     = 3'b101;
  localparam int         OP_ADD_LSB    = 24;
  localparam logic [4:0] OP_ADD        = 5'b10001;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} buffer; head is combinational from storage (0 cycles), zero when empty.
// No internal backpressure: the fetch issue rule keeps pushes away from a full buffer without a pop.
module fetch_fifo
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head_dat
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;

  // Flush drops everything; a pop in the same cycle has already consumed the head.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_dat = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the 1-cycle code memory, buffers {pc, instr} for decode.
// First word valid 2 cycles after issue; 1/cycle steady state; stalls issue when the buffer would overflow.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [CODE_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rd,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [7:0]         dbg_pc
);

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] req_pc;
  logic [PC_W-1:0] issue_pc;
  logic            req_v;
  logic            pop;
  logic            fifo_push;
  logic [1:0]      fifo_count;
  logic [2:0]      occupancy;
  fetch_entry_t    head;

  assign pop = out_valid && out_ready;

  // Occupancy once this cycle settles, counting the word still in flight from memory.
  assign occupancy = {1'b0, fifo_count} + {2'b00, req_v} - {2'b00, pop};
  assign imem_en   = !reset && (redirect_valid || (occupancy < 3'(DEPTH)));
  assign issue_pc  = redirect_valid ? redirect_pc : fetch_pc;
  assign imem_addr = issue_pc[CODE_AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_v    <= 1'b0;
      req_pc   <= '0;
    end else if (imem_en) begin
      fetch_pc <= issue_pc + PC_W'(1);
      req_v    <= 1'b1;
      req_pc   <= issue_pc;
    end else begin
      req_v    <= 1'b0;
    end
  end

  // Words returning during a redirect belong to the abandoned path.
  assign fifo_push = req_v && !redirect_valid;

  fetch_fifo u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat ('{pc: req_pc, instr: imem_rd}),
    .pop      (pop),
    .flush    (redirect_valid),
    .count    (fifo_count),
    .head_dat (head)
  );

  assign out_valid = (fifo_count != 2'd0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign dbg_pc    = fetch_pc[7:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios queue expected {pc, instr, cycle};
// a monitor pops on each accepted output and also watches stall stability and overflow.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_en;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rd = '0;
  logic        redirect_valid = 1'b0;
  logic [29:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [29:0] out_pc;
  logic [31:0] out_instr;
  logic [7:0]  dbg_pc;

  int cyc = 0;
  int t0 = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [29:0] pc;
    logic [31:0] instr;
    int          c;
  } exp_t;

  exp_t exp_q[$];

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .dbg_pc         (dbg_pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Code memory: mem[i] = 0x1000_0000 + i, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rd <= 32'h1000_0000 + {23'b0, imem_addr};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  task automatic expect_out(input logic [29:0] pc, input logic [31:0] instr, input int c);
    exp_t e;
    e.pc = pc;
    e.instr = instr;
    e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int c);
    while ((cyc - t0) < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_imem_en", 64'(imem_en), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    t0 = cyc;
  endtask

  task automatic end_test(input string name);
    reset = 1'b1;
    chk(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic monitor();
    exp_t        e;
    logic        prev_stall;
    logic [29:0] prev_pc;
    logic [31:0] prev_instr;
    prev_stall = 1'b0;
    prev_pc = '0;
    prev_instr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        chk("no_full_push", 64'(dut.fifo_push && (dut.fifo_count == 2'd2) && !dut.pop), 64'd0);
        if (prev_stall) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_pc", 64'(out_pc), 64'(prev_pc));
          chk("stall_instr", 64'(out_instr), 64'(prev_instr));
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got pc=0x%0h instr=0x%0h at cycle %0d, expected no output",
                     out_pc, out_instr, cyc - t0);
          end else begin
            e = exp_q.pop_front();
            if (out_pc !== e.pc || out_instr !== e.instr || (cyc - t0) != e.c) begin
              errors++;
              $display("FAIL sb_pop: got pc=0x%0h instr=0x%0h cycle=%0d, expected pc=0x%0h instr=0x%0h cycle=%0d",
                       out_pc, out_instr, cyc - t0, e.pc, e.instr, e.c);
            end
          end
        end
        prev_stall = out_valid && !out_ready && !redirect_valid;
        prev_pc = out_pc;
        prev_instr = out_instr;
      end
    end
  endtask

  task automatic redirect_wrap(input logic [29:0] tgt, input logic [29:0] p1, input logic [29:0] p2,
                               input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2,
                               input logic [8:0] a0, input logic [8:0] a1);
    do_reset();
    out_ready = 1'b1;
    expect_out(30'd0, 32'h1000_0000, 2);
    expect_out(30'd1, 32'h1000_0001, 3);
    expect_out(tgt, i0, 5);
    expect_out(p1, i1, 6);
    expect_out(p2, i2, 7);
    goto(3);
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    @(negedge clk);
    chk("wrap_addr_tgt", 64'(imem_addr), 64'(a0));
    goto(4);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_addr_next", 64'(imem_addr), 64'(a1));
    chk("wrap_gap", 64'(out_valid), 64'd0);
    goto(8);
    end_test("wrap_drained");
  endtask

  task automatic stimulus();
    // Straight-line fetch at full throughput.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) expect_out(30'(k), 32'h1000_0000 + 32'(k), k + 2);
    @(negedge clk);
    chk("c0_imem_en", 64'(imem_en), 64'd1);
    chk("c0_imem_addr", 64'(imem_addr), 64'd0);
    goto(1);
    @(negedge clk);
    chk("c1_out_valid", 64'(out_valid), 64'd0);
    chk("c1_out_instr", 64'(out_instr), 64'd0);
    goto(3);
    @(negedge clk);
    chk("c3_dbg_pc", 64'(dbg_pc), 64'd3);
    goto(10);
    end_test("seq_drained");

    // Decode stalls during cycles 3-6.
    do_reset();
    out_ready = 1'b1;
    expect_out(30'd0, 32'h1000_0000, 2);
    for (int k = 1; k < 6; k++) expect_out(30'(k), 32'h1000_0000 + 32'(k), k + 6);
    goto(3);
    out_ready = 1'b0;
    @(negedge clk);
    chk("stall_c3_en", 64'(imem_en), 64'd0);
    goto(5);
    @(negedge clk);
    chk("stall_c5_en", 64'(imem_en), 64'd0);
    chk("stall_c5_count", 64'(dut.fifo_count), 64'd2);
    goto(7);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_c7_en", 64'(imem_en), 64'd1);
    goto(12);
    end_test("stall_drained");

    // Redirect to 0x40 at cycle 5 while streaming.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) expect_out(30'(k), 32'h1000_0000 + 32'(k), k + 2);
    for (int j = 0; j < 4; j++) expect_out(30'h40 + 30'(j), 32'h1000_0040 + 32'(j), j + 7);
    goto(5);
    redirect_valid = 1'b1;
    redirect_pc = 30'h40;
    @(negedge clk);
    chk("redir_addr", 64'(imem_addr), 64'h40);
    chk("redir_en", 64'(imem_en), 64'd1);
    goto(6);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_gap", 64'(out_valid), 64'd0);
    goto(11);
    end_test("redir_drained");

    // Redirect to 0x10 with a full buffer and decode stalled.
    do_reset();
    out_ready = 1'b0;
    expect_out(30'h10, 32'h1000_0010, 6);
    expect_out(30'h11, 32'h1000_0011, 7);
    expect_out(30'h12, 32'h1000_0012, 8);
    goto(4);
    redirect_valid = 1'b1;
    redirect_pc = 30'h10;
    @(negedge clk);
    chk("full_count", 64'(dut.fifo_count), 64'd2);
    chk("full_head_pc", 64'(out_pc), 64'd0);
    goto(5);
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_flushed", 64'(out_valid), 64'd0);
    goto(9);
    end_test("full_drained");

    // Code address aliasing and PC wrap.
    redirect_wrap(30'd511, 30'd512, 30'd513, 32'h1000_01FF, 32'h1000_0000, 32'h1000_0001, 9'h1FF, 9'h000);
    redirect_wrap(30'h3FFF_FFFF, 30'd0, 30'd1, 32'h1000_01FF, 32'h1000_0000, 32'h1000_0001, 9'h1FF, 9'h000);

    // Reset and redirect together mid-stream.
    do_reset();
    out_ready = 1'b1;
    expect_out(30'd0, 32'h1000_0000, 2);
    expect_out(30'd1, 32'h1000_0001, 3);
    goto(4);
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 30'h33;
    @(negedge clk);
    chk("rr_c4_en", 64'(imem_en), 64'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("rr_c5_valid", 64'(out_valid), 64'd0);
    chk("rr_c5_en", 64'(imem_en), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    t0 = cyc;
    expect_out(30'd0, 32'h1000_0000, 2);
    expect_out(30'd1, 32'h1000_0001, 3);
    expect_out(30'd2, 32'h1000_0002, 4);
    goto(5);
    end_test("rr_drained");
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the cpu decode/execute stage. It owns the PC, drives the synchronous code memory read port and absorbs the memory's 1-cycle read latency in a small buffer. It presents {pc, instr} pairs to decode through a valid/ready handshake and accepts branch redirects back from decode.

Parameters:
PC_W, 30, PC width in words; the PC is word-indexed and increments by 1.
CODE_AW, 9, code memory address width (512 words).
DEPTH, 2, output buffer entries (fixed at 2, which is required for full throughput).
RESET_PC, 0, PC loaded on reset.

Ports:
clk  in  1  clock
reset  in  1  synchronous reset
imem_en  out  1  read strobe; the request is issued this cycle
imem_addr  out  CODE_AW  read address, equal to the low CODE_AW bits of the issued PC
imem_rd  in  32  read data, valid 1 cycle after imem_en
redirect_valid  in  1  branch redirect from decode
redirect_pc  in  PC_W  redirect target
out_valid  out  1  buffer head valid
out_ready  in  1  decode accepts the head
out_pc  out  PC_W  PC of head instruction
out_instr  out  32  head instruction word
dbg_pc  out  8  fetch_pc[7:0]

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- State:
  - fetch_pc: next PC to request.
  - req_v / req_pc: a request issued last cycle.
  - 2-entry FIFO of {pc, instr} with count 0..2.
- Reset: fetch_pc<=RESET_PC, req_v<=0, count<=0.
  - Outputs after reset: out_valid=0, imem_en=0, out_pc=0, out_instr=0.
  - Reset has priority over redirect and over every handshake.
  - Reset mid-stream discards all buffered and in-flight words.
- pop = out_valid && out_ready.
- Issue rule:
  - imem_en = !reset && (redirect_valid || (count + req_v - pop) < DEPTH).
  - Issued PC = redirect_valid ? redirect_pc : fetch_pc.
  - On issue: fetch_pc <= issued PC + 1, req_v<=1, req_pc<=issued PC. Otherwise req_v<=0.
- Arrival: when req_v=1, {req_pc, imem_rd} is pushed into the FIFO at the end of the cycle.
  - A simultaneous push and pop is legal at count 1 or 2.
  - The issue rule guarantees no push into a full FIFO with no pop. The bench asserts this.
- Output: out_valid = (count != 0). out_pc and out_instr come from the head.
  - Values stay stable while out_valid && !out_ready.
  - Outputs are zero when the FIFO is empty.
- Latency and throughput:
  - The first request issues in the cycle after reset deasserts (cycle 0).
  - out_valid rises at cycle 2.
  - Steady throughput is 1 instruction/cycle with out_ready held high.
- Redirect, in cycle t:
  - A pop in cycle t completes normally.
  - All other FIFO entries are flushed (count<=0).
  - Data arriving in cycle t (from req_v) is discarded.
  - redirect_pc is issued in cycle t.
  - out_valid=0 at t+1; the target instruction appears at t+2.
  - Back-to-back redirects: the latest one wins.
- Wrap-around:
  - fetch_pc wraps modulo 2^PC_W.
  - imem_addr aliases modulo 2^CODE_AW, while out_pc carries the full PC.
- No decode of instruction bits occurs in this block.

Decomposition:
- Package cpu_pkg holds:
  - PC_W and instruction width (32).
  - RESET_PC.
  - Opcode field constants shared with decode: branch [27:25]=3'b101, add [28:24]=5'b10001.
- One sub-module, fetch_fifo: 2-entry synchronous FIFO with push, pop and flush inputs, and count/head outputs.

Test Plan:
- Reset, out_ready=1, mem[i]=0x1000_0000+i -> out_valid first at cycle 2, with out_pc=0 and out_instr=0x10000000. Then pc 1,2,3... one per cycle with no gaps.
- out_ready=0 during cycles 3-6 -> count saturates at 2 and imem_en drops. After out_ready returns, the sequence resumes with no loss and no duplicates, and out_pc/out_instr stay stable while stalled.
- redirect_valid=1, redirect_pc=0x40 at cycle 5 with out_ready=1 -> out_valid=0 at cycle 6. Cycle 7 gives out_pc=0x40 and instr mem[0x40]. PCs that were in flight never appear.
- Redirect to 0x10 while the FIFO is full and out_ready=0 -> FIFO is empty next cycle. The next valid output is pc 0x10, followed by 0x11.
- redirect_pc=511 -> outputs pc 511 (mem[511]), then pc 512 with imem_addr=0 and out_instr=mem[0].
- reset and redirect_valid asserted in the same cycle mid-stream -> out_valid=0 and imem_en=0 next cycle. Restart at RESET_PC with valid data 2 cycles after reset deasserts.
